// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-bus arbiter: FSM states, owner IDs and
// the word returned to a requester when a bus transaction is abandoned.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant. req[0] is the fetch port, req[1] the data port.
// On a tie the port that was not served last wins, so neither can starve.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       gnt_vld,
    output owner_t     gnt_owner
);

    // Pick the winner from the eligible set and the previous owner
    always_comb begin
        gnt_vld   = |req;
        gnt_owner = OWN_INST;
        if (req[1] && req[0]) begin
            gnt_owner = (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (req[1]) begin
            gnt_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises the CPU fetch and data ports onto one SRAM-like bus, one
// outstanding transaction at a time, with round-robin on contention.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abandon a transaction after
// TIMEOUT_CYCLES cycles, returning ERR_WORD and setting the sticky err flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    output logic          i_stall,
    input  logic          d_req,
    input  logic [3:0]    d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          d_stall,
    output logic          bus_req,
    output logic [3:0]    bus_wen,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,
    input  logic [DW-1:0] bus_rdata,
    output logic          err
);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          gnt_vld;
    owner_t        gnt_owner;
    logic          fin;
    logic [DW-1:0] fin_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES) + 1 > 8) ? $clog2(TIMEOUT_CYCLES) + 1 : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // A port whose ready is pulsing this cycle is still finishing, not asking again
    arb_rr2 u_rr (
        .req       ({d_req & ~d_ready_q, i_req & ~i_ready_q}),
        .last_owner(last_q),
        .gnt_vld   (gnt_vld),
        .gnt_owner (gnt_owner)
    );

    // Next-state, request latching and completion handling
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        fin       = 1'b0;
        fin_data  = bus_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_owner;
                    if (gnt_owner == OWN_DATA) begin
                        addr_d  = d_addr;
                        wen_d   = d_wen;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = i_addr;
                        wen_d   = 4'b0000;
                        wdata_d = '0;
                    end
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) fin = 1'b1;
                    else             state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) fin = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef MEM_ARB_TIMEOUT_EN
        // Counter sits at zero in IDLE, so it starts from zero on entry to ADDR
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (!fin) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                fin      = 1'b1;
                fin_data = DW'(ERR_WORD);
                err_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
        if (fin) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
            if (owner_q == OWN_DATA) begin
                d_ready_d = 1'b1;
                d_rdata_d = fin_data;
            end else begin
                i_ready_d = 1'b1;
                i_rdata_d = fin_data;
            end
        end
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_INST;
            last_q    <= OWN_INST;
            addr_q    <= '0;
            wen_q     <= '0;
            wdata_q   <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Bus is driven only during the address phase, quiet otherwise
    assign bus_req   = (state_q == ST_ADDR);
    assign bus_addr  = bus_req ? addr_q  : '0;
    assign bus_wen   = bus_req ? wen_q   : 4'b0000;
    assign bus_wdata = bus_req ? wdata_q : '0;

    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_stall = i_req & ~i_ready_q;
    assign d_stall = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default build, watchdog compiled out).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_stall;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        bus_req;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        err;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .i_stall    (i_stall),
        .d_req      (d_req),
        .d_wen      (d_wen),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .d_stall    (d_stall),
        .bus_req    (bus_req),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int          busreq_cnt;
    int          ready_cyc;
    logic        stall_ok;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;

    initial begin
        rst = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wen = '0; d_addr = '0; d_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

        // ---- reset state
        step();
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wen", {28'd0, bus_wen}, 32'd0);
        chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // ---- fetch only: addr_ok in N+1, data_ok in N+2, ready in N+3
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'hBFC0_0000; bus_addr_ok = 1'b1;
        #1;
        chk("f_stall_idle", {31'd0, i_stall}, 32'd1);
        chk("f_busreq_idle", {31'd0, bus_req}, 32'd0);
        step();
        chk("f_busreq_addr", {31'd0, bus_req}, 32'd1);
        chk("f_bus_addr", bus_addr, 32'hBFC0_0000);
        chk("f_bus_wen", {28'd0, bus_wen}, 32'd0);
        step();
        chk("f_busreq_data", {31'd0, bus_req}, 32'd0);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C01_0001;
        step();
        chk("f_i_ready", {31'd0, i_ready}, 32'd1);
        chk("f_i_rdata", i_rdata, 32'h3C01_0001);
        chk("f_i_stall_rdy", {31'd0, i_stall}, 32'd0);
        chk("f_d_ready", {31'd0, d_ready}, 32'd0);
        bus_data_ok = 1'b0; bus_rdata = 32'hFFFF_FFFF;
        step();
        chk("f_ready_pulse", {31'd0, i_ready}, 32'd0);
        chk("f_no_reissue", {31'd0, bus_req}, 32'd0);
        chk("f_rdata_hold", i_rdata, 32'h3C01_0001);
        i_req = 1'b0; i_addr = '0;

        // ---- store with partial byte enables; inputs changed mid-transaction
        d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h8000_0006; d_wdata = 32'hABCD_ABCD;
        bus_addr_ok = 1'b1;
        step();
        chk("s_busreq", {31'd0, bus_req}, 32'd1);
        chk("s_bus_wen", {28'd0, bus_wen}, 32'h3);
        chk("s_bus_addr", bus_addr, 32'h8000_0006);
        chk("s_bus_wdata", bus_wdata, 32'hABCD_ABCD);
        chk("s_d_stall", {31'd0, d_stall}, 32'd1);
        d_addr = 32'h0; d_wdata = 32'h0; d_wen = 4'b1111;
        step();
        chk("s_busreq_data", {31'd0, bus_req}, 32'd0);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
        step();
        chk("s_d_ready", {31'd0, d_ready}, 32'd1);
        chk("s_d_rdata", d_rdata, 32'h1111_2222);
        chk("s_i_ready", {31'd0, i_ready}, 32'd0);
        chk("s_i_rdata_hold", i_rdata, 32'h3C01_0001);
        bus_data_ok = 1'b0; d_req = 1'b0; d_wen = 4'b0000;
        step();
        chk("s_ready_pulse", {31'd0, d_ready}, 32'd0);
        chk("s_idle", {31'd0, bus_req}, 32'd0);

        // ---- contention from reset: data, inst, data, inst
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_addr = 32'h0000_0200; d_wen = 4'b0000; d_wdata = '0;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = '0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
            exp_rd   = 32'hA000_0000 + k;
            step();
            chk("c_busreq", {31'd0, bus_req}, 32'd1);
            chk("c_order_addr", bus_addr, exp_addr);
            bus_rdata = exp_rd;
            step();
            if (k % 2 == 0) begin
                chk("c_d_ready", {31'd0, d_ready}, 32'd1);
                chk("c_i_quiet", {31'd0, i_ready}, 32'd0);
                chk("c_d_rdata", d_rdata, exp_rd);
            end else begin
                chk("c_i_ready", {31'd0, i_ready}, 32'd1);
                chk("c_d_quiet", {31'd0, d_ready}, 32'd0);
                chk("c_i_rdata", i_rdata, exp_rd);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        step();

        // ---- slow slave: addr_ok after 3 waits, data_ok 5 cycles later
        i_req = 1'b1; i_addr = 32'h0000_0300;
        busreq_cnt = 0; ready_cyc = 0; stall_ok = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus_req) busreq_cnt++;
            if (i_ready && ready_cyc == 0) ready_cyc = c;
            if (ready_cyc == 0 && !i_stall) stall_ok = 1'b0;
            bus_addr_ok = (c == 4);
            bus_data_ok = (c == 9);
            bus_rdata   = 32'hCAFE_0001;
            if (c == 10) i_req = 1'b0;
        end
        chk("slow_busreq_cycles", busreq_cnt, 32'd4);
        chk("slow_ready_cycle", ready_cyc, 32'd10);
        chk("slow_stall_held", {31'd0, stall_ok}, 32'd1);
        chk("slow_i_rdata", i_rdata, 32'hCAFE_0001);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

        // ---- reset while in DATA, then a normal fetch
        i_req = 1'b1; i_addr = 32'h0000_0400; bus_addr_ok = 1'b1;
        step();
        step();
        chk("r_in_data", {31'd0, bus_req}, 32'd0);
        chk("r_stall", {31'd0, i_stall}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("r_async_i_rdata", i_rdata, 32'd0);
        chk("r_async_d_rdata", d_rdata, 32'd0);
        chk("r_async_busreq", {31'd0, bus_req}, 32'd0);
        chk("r_async_i_ready", {31'd0, i_ready}, 32'd0);
        step();
        rst = 1'b1;
        i_addr = 32'h0000_0040; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        bus_rdata = 32'h55AA_55AA;
        step();
        chk("r_after_busreq", {31'd0, bus_req}, 32'd1);
        chk("r_after_addr", bus_addr, 32'h0000_0040);
        step();
        chk("r_after_ready", {31'd0, i_ready}, 32'd1);
        chk("r_after_rdata", i_rdata, 32'h55AA_55AA);
        i_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        step();
        chk("r_after_pulse", {31'd0, i_ready}, 32'd0);
        chk("err_default", {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
